// File: rtl/cp0_reg_pkg.sv
// -----------------------------------------------------------------------------
// cp0_reg_pkg
// Shared definitions for the CP0 register file:
//   - CP0 register numbers addressed by MFC0/MTC0
//   - ExcCode values written into Cause[6:2]
//   - excepttype codes delivered by the MEM/exception path
//   - Status/Cause bit positions and the Cause software-writable mask
//   - decode_exc(): maps an excepttype code onto the action CP0 must commit
// -----------------------------------------------------------------------------
package cp0_reg_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  // excepttype codes from the MEM stage
  localparam logic [31:0] EXCEPT_INT  = 32'h0000_0001;
  localparam logic [31:0] EXCEPT_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXCEPT_RI   = 32'h0000_000a;
  localparam logic [31:0] EXCEPT_OV   = 32'h0000_000c;
  localparam logic [31:0] EXCEPT_TR   = 32'h0000_000d;
  localparam logic [31:0] EXCEPT_ERET = 32'h0000_000e;

  // ExcCode field values
  typedef enum logic [4:0] {
    EXC_INT = 5'h00,
    EXC_SYS = 5'h08,
    EXC_RI  = 5'h0a,
    EXC_OV  = 5'h0c,
    EXC_TR  = 5'h0d
  } exc_code_e;

  // Status bit positions
  localparam int STATUS_EXL = 1;

  // Cause bit positions
  localparam int CAUSE_BD         = 31;
  localparam int CAUSE_IP_HW_MSB  = 15;
  localparam int CAUSE_IP_HW_LSB  = 10;
  localparam int CAUSE_EXC_MSB    = 6;
  localparam int CAUSE_EXC_LSB    = 2;

  // Software may only touch IV[23], WP[22] and IP1:0[9:8]
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

  // What an excepttype code asks CP0 to do on this edge
  typedef struct packed {
    logic      take;      // enter exception: EXL<=1, ExcCode, maybe EPC/BD
    logic      eret;      // return: EXL<=0
    exc_code_e exc_code;
  } exc_action_t;

  function automatic exc_action_t decode_exc(input logic [31:0] excepttype);
    exc_action_t act;
    act = '{take: 1'b0, eret: 1'b0, exc_code: EXC_INT};
    case (excepttype)
      EXCEPT_INT:  begin act.take = 1'b1; act.exc_code = EXC_INT; end
      EXCEPT_SYS:  begin act.take = 1'b1; act.exc_code = EXC_SYS; end
      EXCEPT_RI:   begin act.take = 1'b1; act.exc_code = EXC_RI;  end
      EXCEPT_OV:   begin act.take = 1'b1; act.exc_code = EXC_OV;  end
      EXCEPT_TR:   begin act.take = 1'b1; act.exc_code = EXC_TR;  end
      EXCEPT_ERET: act.eret = 1'b1;
      default:     ;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/cp0_reg_timer.sv
// -----------------------------------------------------------------------------
// cp0_reg_timer
// Count/Compare timer of the CP0 register file. Only built when CP0_TIMER_EN
// is defined; otherwise cp0_reg keeps plain Count/Compare registers itself.
//   clk, resetn    : clock, synchronous active-low reset
//   count_we       : MTC0 to Count this cycle (load instead of increment)
//   compare_we     : MTC0 to Compare this cycle (also clears the interrupt)
//   wdata          : MTC0 write data
//   count_o        : Count register
//   compare_o      : Compare register
//   timer_int_o    : sticky timer interrupt request
// -----------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
module cp0_reg_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_int_q;
  logic        match;

  // Compare == 0 is treated as "timer disarmed".
  assign match = (compare_q != 32'd0) && (count_q == compare_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      // Wraps naturally from 32'hFFFF_FFFF to 0.
      count_q <= count_we ? wdata : count_q + 32'd1;
      if (compare_we) begin
        compare_q   <= wdata;
        timer_int_q <= 1'b0;   // Compare write wins over a same-cycle match
      end else if (match) begin
        timer_int_q <= 1'b1;
      end
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule
`endif

// File: rtl/cp0_reg.sv
// -----------------------------------------------------------------------------
// cp0_reg
// Coprocessor-0 register file: answers the EXE-stage MFC0 read port, accepts
// registered MTC0 writes, commits exception/ERET side effects from the MEM
// stage and raises the timer interrupt.
// Build option: define CP0_TIMER_EN to enable the Count increment and the
// Compare-match timer interrupt (cp0_reg_timer). Without it Count only
// changes by MTC0 and timer_int_o is tied low.
// Ports:
//   clk, resetn               : clock, synchronous active-low reset
//   we_i, waddr_i, data_i     : MTC0 write channel
//   raddr_i, data_o           : MFC0 read port (combinational)
//   int_i                     : hardware interrupts IP7..IP2 -> Cause[15:10]
//   excepttype_i              : final exception code from MEM
//   current_inst_addr_i       : PC of the excepting instruction
//   is_in_delayslot_i         : excepting instruction sits in a delay slot
//   count_o .. prid_o         : direct register views
//   timer_int_o               : timer interrupt request
// -----------------------------------------------------------------------------
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_RST = 32'h0000_8000,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q,  cause_d;
  logic [31:0] epc_q,    epc_d;
  logic        count_we, compare_we;
  exc_action_t exc;
  logic [31:0] rdata;

  assign count_we   = we_i && (waddr_i == CP0_REG_COUNT);
  assign compare_we = we_i && (waddr_i == CP0_REG_COMPARE);
  assign exc        = decode_exc(excepttype_i);

  // ---------------------------------------------------------------------------
  // Count / Compare / timer interrupt
  // ---------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
  cp0_reg_timer u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .count_we    (count_we),
    .compare_we  (compare_we),
    .wdata       (data_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int_o)
  );
`else
  logic [31:0] count_q;
  logic [31:0] compare_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
    end else begin
      if (count_we)   count_q   <= data_i;
      if (compare_we) compare_q <= data_i;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Status / Cause / EPC next state. MTC0 is applied first, then the hardware
  // interrupt sample, then the exception commit, so the exception wins on any
  // field both touch.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default on entry, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;

    if (we_i) begin
      case (waddr_i)
        CP0_REG_STATUS: status_d = data_i;
        CP0_REG_CAUSE:  cause_d  = (cause_q & ~CAUSE_WR_MASK) | (data_i & CAUSE_WR_MASK);
        CP0_REG_EPC:    epc_d    = data_i;
        default:        ;
      endcase
    end

    cause_d[CAUSE_IP_HW_MSB:CAUSE_IP_HW_LSB] = int_i;

    if (exc.take) begin
      // A nested exception (EXL already set) keeps the original return point.
      if (!status_q[STATUS_EXL]) begin
        epc_d            = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                             : current_inst_addr_i;
        cause_d[CAUSE_BD] = is_in_delayslot_i;
      end
      status_d[STATUS_EXL]                  = 1'b1;
      cause_d[CAUSE_EXC_MSB:CAUSE_EXC_LSB]  = exc.exc_code;
    end else if (exc.eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q <= STATUS_RST;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port. No write bypass: EXE forwards in-flight MTC0 data itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = 32'd0;
    case (raddr_i)
      CP0_REG_COUNT:   rdata = count_o;
      CP0_REG_COMPARE: rdata = compare_o;
      CP0_REG_STATUS:  rdata = status_q;
      CP0_REG_CAUSE:   rdata = cause_q;
      CP0_REG_EPC:     rdata = epc_q;
      CP0_REG_PRID:    rdata = PRID_VAL;
      CP0_REG_CONFIG:  rdata = CONFIG_RST;
      default:         rdata = 32'd0;
    endcase
  end

  assign data_o   = resetn ? rdata : 32'd0;

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  // PRId and Config ignore writes, so they are constants rather than flops.
  assign config_o = CONFIG_RST;
  assign prid_o   = PRID_VAL;

endmodule

// File: tb/tb_cp0_reg.sv
// -----------------------------------------------------------------------------
// tb_cp0_reg
// Self-checking bench for cp0_reg: directed scenarios followed by random
// MTC0/exception/interrupt traffic, every cycle compared with a behavioural
// model of the CP0 registers. Follows CP0_TIMER_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_cp0_reg;

`ifdef CP0_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [31:0] PRID   = 32'h004C_0102;
  localparam logic [31:0] CONFIG = 32'h0000_8000;
  localparam logic [31:0] STATUS = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_tint;

  always #5 clk = ~clk;

  cp0_reg dut (
    .clk                 (clk),
    .resetn              (resetn),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .data_i              (data_i),
    .raddr_i             (raddr_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Architectural view of an MFC0 read.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (!resetn) return 32'd0;
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return CONFIG;
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of CP0 behaviour, computed from the pre-edge state.
  task automatic model_step();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, et;
    logic        n_tint;
    if (!resetn) begin
      m_count = 0; m_compare = 0; m_cause = 0; m_epc = 0;
      m_status = STATUS; m_tint = 0;
      return;
    end
    n_count = m_count; n_compare = m_compare; n_status = m_status;
    n_cause = m_cause; n_epc = m_epc; n_tint = m_tint;
    if (TIMER_EN) begin
      n_count = m_count + 1;
      if (m_compare != 0 && m_count == m_compare) n_tint = 1;
    end
    if (we_i) begin
      if (waddr_i == 9)  n_count = data_i;
      if (waddr_i == 11) begin n_compare = data_i; n_tint = 0; end
      if (waddr_i == 12) n_status = data_i;
      if (waddr_i == 13) n_cause = (m_cause & ~32'h00C0_0300) | (data_i & 32'h00C0_0300);
      if (waddr_i == 14) n_epc = data_i;
    end
    n_cause = (n_cause & ~32'h0000_FC00) | (32'(int_i) << 10);
    et = excepttype_i;
    if (et inside {32'h1, 32'h8, 32'ha, 32'hc, 32'hd}) begin
      if (m_status[1] == 1'b0) begin
        n_epc   = is_in_delayslot_i ? et_addr_minus4() : current_inst_addr_i;
        n_cause = is_in_delayslot_i ? (n_cause | 32'h8000_0000) : (n_cause & 32'h7FFF_FFFF);
      end
      n_status = n_status | 32'h2;
      n_cause  = (n_cause & ~32'h7C) | (32'((et == 32'h1) ? 32'd0 : et) << 2);
    end else if (et == 32'he) begin
      n_status = n_status & ~32'h2;
    end
    m_count = n_count; m_compare = n_compare; m_status = n_status;
    m_cause = n_cause; m_epc = n_epc; m_tint = n_tint;
  endtask

  function automatic logic [31:0] et_addr_minus4();
    return current_inst_addr_i - 32'd4;
  endfunction

  task automatic compare_all();
    check("count",     count_o,            m_count);
    check("compare",   compare_o,          m_compare);
    check("status",    status_o,           m_status);
    check("cause",     cause_o,            m_cause);
    check("epc",       epc_o,              m_epc);
    check("config",    config_o,           CONFIG);
    check("prid",      prid_o,             PRID);
    check("timer_int", {31'd0, timer_int_o}, {31'd0, m_tint});
    check("data_o",    data_o,             model_read(raddr_i));
  endtask

  // Apply the current inputs across one edge, then compare away from the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    we_i = 0; waddr_i = 0; data_i = 0; excepttype_i = 0;
    current_inst_addr_i = 0; is_in_delayslot_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1; waddr_i = a; data_i = d;
    tick();
    we_i = 0;
  endtask

  function automatic logic [4:0] pick_addr();
    logic [4:0] regs [7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 31));
    return regs[$urandom_range(0, 6)];
  endfunction

  initial begin
    logic [31:0] codes [8] = '{32'h0, 32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h5};
    set_idle();
    resetn = 0; raddr_i = 5'd15; int_i = 0;

    // Reset: two cycles low, read port forced to 0 meanwhile
    tick(); tick();
    check("rst_status", status_o, 32'h1000_0000);
    check("rst_config", config_o, 32'h0000_8000);
    check("rst_count",  count_o,  32'd0);
    check("rst_tint",   {31'd0, timer_int_o}, 32'd0);
    check("rst_rd_zero", data_o, 32'd0);
    resetn = 1; #1;
    check("rd_prid", data_o, 32'h004C_0102);

    if (TIMER_EN) begin
      // Compare=5 written while Count=0
      mtc0(5'd11, 32'd5);
      check("cnt_after_wr", count_o, 32'd1);
      repeat (4) tick();
      check("cnt_eq_5",   count_o, 32'd5);
      check("tint_pre",   {31'd0, timer_int_o}, 32'd0);
      tick();
      check("tint_rise",  {31'd0, timer_int_o}, 32'd1);
      repeat (3) tick();
      check("tint_stick", {31'd0, timer_int_o}, 32'd1);
      mtc0(5'd11, 32'h100);
      check("tint_clr",   {31'd0, timer_int_o}, 32'd0);
      mtc0(5'd9, 32'hFFFF_FFFF);
      tick();
      check("cnt_wrap",   count_o, 32'd0);
    end else begin
      repeat (3) tick();
      check("cnt_hold0",  count_o, 32'd0);
      mtc0(5'd11, 32'd5);
      check("cmp_wr",     compare_o, 32'd5);
      mtc0(5'd9, 32'h1234);
      repeat (6) tick();
      check("cnt_hold",   count_o, 32'h1234);
      check("tint_tied",  {31'd0, timer_int_o}, 32'd0);
    end

    // Syscall in a delay slot with EXL=0
    excepttype_i = 32'h8; current_inst_addr_i = 32'h0040_0104; is_in_delayslot_i = 1;
    tick(); set_idle();
    check("sys_epc",  epc_o, 32'h0040_0100);
    check("sys_bd",   {31'd0, cause_o[31]}, 32'd1);
    check("sys_exc",  {27'd0, cause_o[6:2]}, 32'h8);
    check("sys_exl",  {31'd0, status_o[1]}, 32'd1);

    // Nested overflow: EPC and BD kept, ExcCode updated
    excepttype_i = 32'hc; current_inst_addr_i = 32'h8000_0010;
    tick(); set_idle();
    check("nest_epc", epc_o, 32'h0040_0100);
    check("nest_bd",  {31'd0, cause_o[31]}, 32'd1);
    check("nest_exc", {27'd0, cause_o[6:2]}, 32'hc);
    excepttype_i = 32'he;
    tick(); set_idle();
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);

    // Status write colliding with an interrupt commit
    we_i = 1; waddr_i = 5'd12; data_i = 32'h0000_FF01; excepttype_i = 32'h1;
    current_inst_addr_i = 32'h0000_2000;
    tick(); set_idle();
    check("coll_status", status_o, 32'h0000_FF03);

    // Cause write masking and hardware interrupt sampling
    mtc0(5'd13, 32'hFFFF_FFFF);
    raddr_i = 5'd13; #1;
    check("cause_mask", data_o, 32'h00C0_0300);
    int_i = 6'b100001;
    tick();
    check("cause_ip", {26'd0, cause_o[15:10]}, 32'h21);
    raddr_i = 5'd3; #1;
    check("rd_unmapped", data_o, 32'd0);
    int_i = 0;

    // Reset wins over a simultaneous write and exception
    resetn = 0; we_i = 1; waddr_i = 5'd14; data_i = 32'hDEAD_BEEF;
    excepttype_i = 32'h8; current_inst_addr_i = 32'h100;
    tick(); set_idle(); resetn = 1;
    check("rst_epc",    epc_o, 32'd0);
    check("rst_status2", status_o, 32'h1000_0000);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      resetn              = ($urandom_range(0, 199) != 0);
      we_i                = ($urandom_range(0, 2) == 0);
      waddr_i             = pick_addr();
      data_i              = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 24);
      raddr_i             = pick_addr();
      int_i               = 6'($urandom);
      excepttype_i        = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 7)] : 32'd0;
      current_inst_addr_i = $urandom;
      is_in_delayslot_i   = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
